// File: rtl/heart_beat_monitor.sv
// heart_beat_monitor: receive-side liveness checker for a toggling heartbeat.
// It synchronises the heartbeat line, detects both edges, measures the
// edge-to-edge interval and runs a lock FSM over the classified intervals.
//
// Ports:
//   clk_i           monitor clock
//   srst_i          synchronous reset, active-high
//   heart_beat_i    heartbeat line, may be asynchronous to clk_i
//   locked_o        1 while in LOCKED
//   lost_o          1 while in LOST
//   fast_err_o      one-cycle pulse: interval shorter than the good window
//   slow_err_o      one-cycle pulse: interval longer than the window, or timeout
//   last_interval_o last classified interval in cycles, saturated
module heart_beat_monitor #(
  parameter int unsigned CLK_VALUE   = 100000000,
  parameter int unsigned SPEED_GRADE = 2,
  parameter int unsigned TOLERANCE   = 1000,
  parameter int unsigned LOCK_EDGES  = 3,
  parameter int unsigned SYNC_STAGES = 2,
  localparam int unsigned CNT_W = $clog2(CLK_VALUE / SPEED_GRADE + TOLERANCE + 2)
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic             heart_beat_i,
  output logic             locked_o,
  output logic             lost_o,
  output logic             fast_err_o,
  output logic             slow_err_o,
  output logic [CNT_W-1:0] last_interval_o
);

  localparam int unsigned EXP    = CLK_VALUE / SPEED_GRADE;
  localparam int unsigned WIN_LO = EXP - TOLERANCE;
  localparam int unsigned WIN_HI = EXP + TOLERANCE;
  localparam int unsigned SAT    = WIN_HI + 1;
  localparam int unsigned GOOD_W = $clog2(LOCK_EDGES + 1);

  typedef enum logic [1:0] {
    ST_ACQUIRE = 2'd0,
    ST_LOCKING = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_LOST    = 2'd3
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   edge_q, edge_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   to_fired_q, to_fired_d;
  state_e                 state_q, state_d;
  logic [GOOD_W-1:0]      good_q, good_d;
  logic [CNT_W-1:0]       last_q, last_d;
  logic                   fast_q, fast_d;
  logic                   slow_q, slow_d;
  logic                   locked_q, locked_d;
  logic                   lost_q, lost_d;

  logic edge_det;
  logic cnt_sat;
  logic timeout;
  logic int_good;
  logic int_fast;

  // Synchroniser chain, edge detect and interval counter.
  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], heart_beat_i};
    edge_d   = sync_q[SYNC_STAGES-1];
    edge_det = sync_q[SYNC_STAGES-1] ^ edge_q;
    cnt_sat  = (cnt_q == CNT_W'(SAT));
    // Timeout fires only once per silent stretch; an edge in the same cycle wins.
    timeout  = cnt_sat && !edge_det && !to_fired_q;
    int_fast = (cnt_q < CNT_W'(WIN_LO));
    int_good = !int_fast && (cnt_q <= CNT_W'(WIN_HI));

    cnt_d = cnt_q;
    if (edge_det) begin
      // The edge cycle itself is the first counted cycle of the next interval.
      cnt_d = CNT_W'(1);
    end else if (!cnt_sat) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    to_fired_d = !edge_det && (to_fired_q || timeout);
  end

  // Lock state machine: next state and registered outputs.
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    last_d  = last_q;
    fast_d  = 1'b0;
    slow_d  = 1'b0;

    unique case (state_q)
      ST_ACQUIRE, ST_LOST: begin
        // Reference edge only: starts measurement, nothing is classified.
        if (edge_det) begin
          state_d = ST_LOCKING;
          good_d  = '0;
        end
      end
      ST_LOCKING: begin
        if (edge_det) begin
          last_d = cnt_q;
          if (int_good) begin
            if (good_q == GOOD_W'(LOCK_EDGES - 1)) begin
              state_d = ST_LOCKED;
              good_d  = '0;
            end else begin
              good_d = good_q + GOOD_W'(1);
            end
          end else if (int_fast) begin
            fast_d = 1'b1;
            good_d = '0;
          end else begin
            slow_d  = 1'b1;
            state_d = ST_ACQUIRE;
            good_d  = '0;
          end
        end else if (timeout) begin
          slow_d  = 1'b1;
          state_d = ST_ACQUIRE;
          good_d  = '0;
        end
      end
      ST_LOCKED: begin
        if (edge_det) begin
          last_d = cnt_q;
          if (int_fast) begin
            fast_d  = 1'b1;
            state_d = ST_LOCKING;
            good_d  = '0;
          end else if (!int_good) begin
            slow_d  = 1'b1;
            state_d = ST_LOST;
            good_d  = '0;
          end
        end else if (timeout) begin
          slow_d  = 1'b1;
          state_d = ST_LOST;
          good_d  = '0;
        end
      end
      default: begin
        state_d = ST_ACQUIRE;
        good_d  = '0;
      end
    endcase

    locked_d = (state_d == ST_LOCKED);
    lost_d   = (state_d == ST_LOST);
  end

  // State and datapath registers.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      sync_q     <= '0;
      edge_q     <= 1'b0;
      cnt_q      <= '0;
      to_fired_q <= 1'b0;
      state_q    <= ST_ACQUIRE;
      good_q     <= '0;
      last_q     <= '0;
      fast_q     <= 1'b0;
      slow_q     <= 1'b0;
      locked_q   <= 1'b0;
      lost_q     <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      edge_q     <= edge_d;
      cnt_q      <= cnt_d;
      to_fired_q <= to_fired_d;
      state_q    <= state_d;
      good_q     <= good_d;
      last_q     <= last_d;
      fast_q     <= fast_d;
      slow_q     <= slow_d;
      locked_q   <= locked_d;
      lost_q     <= lost_d;
    end
  end

  assign locked_o        = locked_q;
  assign lost_o          = lost_q;
  assign fast_err_o      = fast_q;
  assign slow_err_o      = slow_q;
  assign last_interval_o = last_q;

endmodule
